// File: rtl/bram_portb_arbiter.sv
// Port-B owner for the shared BRAM: fill sweep (word[i] = i), then round-robin access for NUM_REQ requesters.
// Optional doorbell interrupt on writes to DOORBELL_ADDR when BRAM_DOORBELL_IRQ_EN is defined.
module bram_portb_arbiter #(
  parameter int                NUM_REQ       = 2,
  parameter int                ADDR_W        = 11,
  parameter int                DATA_W        = 32,
  parameter logic [ADDR_W-1:0] DOORBELL_ADDR = 11'h7FF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_start,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      bram_en,
  output logic                      bram_we,
  output logic [ADDR_W-1:0]         bram_addr,
  output logic [DATA_W-1:0]         bram_din,
  input  logic [DATA_W-1:0]         bram_dout,
  output logic                      init_done,
  output logic                      irq_pulse
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ST_INIT, ST_ARB, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q;
  logic [PTR_W-1:0]   ptr_q;
  logic               drain_q;
  logic [NUM_REQ-1:0] issue_q;  // read on the pins this cycle
  logic [NUM_REQ-1:0] rsp_q;    // read data arriving from the BRAM this cycle

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand;
  logic               gnt_any;
  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    grant   = '0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    gnt_any = 1'b0;
    if (state_q == ST_ARB && !init_start) begin
      // Search starts just after the last winner, giving round-robin fairness.
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
      if (gnt_any) grant[gnt_idx] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = bram_dout;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (cnt_q == '1) state_d = ST_ARB;
      ST_ARB:   if (init_start)  state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q)     state_d = ST_INIT;
      default:                   state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      drain_q   <= 1'b0;
      issue_q   <= '0;
      rsp_q     <= '0;
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      init_done <= 1'b0;
    end else begin
      state_q <= state_d;
      rsp_q   <= issue_q;
      issue_q <= '0;
      bram_en <= 1'b0;
      bram_we <= 1'b0;
      drain_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          bram_en   <= 1'b1;
          bram_we   <= 1'b1;
          bram_addr <= cnt_q;
          bram_din  <= DATA_W'(cnt_q);
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == '1) init_done <= 1'b1;
        end
        ST_ARB: begin
          if (init_start) init_done <= 1'b0;
          if (gnt_any) begin
            bram_en   <= 1'b1;
            bram_we   <= req_we[gnt_idx];
            bram_addr <= addr_arr[gnt_idx];
            bram_din  <= wdata_arr[gnt_idx];
            ptr_q     <= gnt_idx;
            if (!req_we[gnt_idx]) issue_q <= grant;
          end
        end
        ST_DRAIN: begin
          drain_q <= 1'b1;
          cnt_q   <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef BRAM_DOORBELL_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_pulse <= 1'b0;
    else     irq_pulse <= gnt_any && req_we[gnt_idx] && (addr_arr[gnt_idx] == DOORBELL_ADDR);
  end
`else
  assign irq_pulse = 1'b0;
`endif

endmodule
